// File: rtl/pair_add_sequencer.sv
// rtl/pair_add_sequencer.sv - two-press slot adder sequencer driving an external pipelined adder
// Define PAIR_ADD_SAT_EN to saturate the written sum on carry instead of wrapping.
module pair_add_sequencer #(
  parameter int N       = 10,
  parameter int W       = 4,
  parameter int ADD_LAT = 1,
  parameter int INIT    = 0,
  localparam int IW     = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [N-1:0]     buttons,
  output logic [W-1:0]     add_a,
  output logic [W-1:0]     add_b,
  output logic             add_req,
  input  logic [W:0]       add_result,
  output logic [N*W-1:0]   values_flat,
  output logic             sel_valid,
  output logic [IW-1:0]    sel_index,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, PICK_B, ADD_WAIT, WRITE} state_t;

  state_t               state_q, state_d;
  logic [N-1:0]         buttons_q, buttons_d;
  logic                 armed_q, armed_d;
  logic [N-1:0][W-1:0]  slots_q, slots_d;
  logic [W-1:0]         add_a_q, add_a_d, add_b_q, add_b_d;
  logic                 add_req_q, add_req_d;
  logic                 sel_valid_q, sel_valid_d;
  logic [IW-1:0]        sel_index_q, sel_index_d;
  logic                 done_q, done_d;
  logic [2:0]           cnt_q, cnt_d;

  logic [N-1:0]         press;
  logic                 press_any;
  logic [IW-1:0]        press_idx;
  logic [W-1:0]         wr_val;

  // The first edge after reset only primes buttons_q, so a held button is not a press.
  assign press = armed_q ? (buttons & ~buttons_q) : '0;

  always_comb begin
    press_any = |press;
    press_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (press[i]) press_idx = IW'(i);
    end
  end

`ifdef PAIR_ADD_SAT_EN
  assign wr_val = add_result[W] ? {W{1'b1}} : add_result[W-1:0];
`else
  assign wr_val = W'(add_result);
`endif

  always_comb begin
    state_d     = state_q;
    buttons_d   = buttons;
    armed_d     = 1'b1;
    slots_d     = slots_q;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    add_req_d   = 1'b0;
    sel_valid_d = sel_valid_q;
    sel_index_d = sel_index_q;
    done_d      = 1'b0;
    cnt_d       = cnt_q;

    case (state_q)
      IDLE: begin
        if (enable && press_any) begin
          sel_index_d = press_idx;
          sel_valid_d = 1'b1;
          state_d     = PICK_B;
        end
      end
      PICK_B: begin
        if (!enable) begin
          sel_valid_d = 1'b0;
          state_d     = IDLE;
        end else if (press_any) begin
          add_a_d   = slots_q[sel_index_q];
          add_b_d   = slots_q[press_idx];
          add_req_d = 1'b1;
          cnt_d     = '0;
          state_d   = ADD_WAIT;
        end
      end
      ADD_WAIT: begin
        // The add_req cycle plus ADD_LAT adder cycles before the sum is sampled.
        if (cnt_q == 3'(ADD_LAT)) begin
          state_d = WRITE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      WRITE: begin
        slots_d[sel_index_q] = wr_val;
        done_d      = 1'b1;
        sel_valid_d = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      buttons_q   <= '0;
      armed_q     <= 1'b0;
      slots_q     <= {N{W'(INIT)}};
      add_a_q     <= '0;
      add_b_q     <= '0;
      add_req_q   <= 1'b0;
      sel_valid_q <= 1'b0;
      sel_index_q <= '0;
      done_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      buttons_q   <= buttons_d;
      armed_q     <= armed_d;
      slots_q     <= slots_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      add_req_q   <= add_req_d;
      sel_valid_q <= sel_valid_d;
      sel_index_q <= sel_index_d;
      done_q      <= done_d;
      cnt_q       <= cnt_d;
    end
  end

  assign add_a       = add_a_q;
  assign add_b       = add_b_q;
  assign add_req     = add_req_q;
  assign values_flat = slots_q;
  assign sel_valid   = sel_valid_q;
  assign sel_index   = sel_index_q;
  assign busy        = (state_q == ADD_WAIT) || (state_q == WRITE);
  assign done        = done_q;

endmodule

// File: tb/tb_pair_add_sequencer.sv
// tb/tb_pair_add_sequencer.sv - directed vector bench for pair_add_sequencer
module tb_pair_add_sequencer;
  localparam int N = 10, W = 4, ADD_LAT = 1, INIT = 3, IW = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              enable;
  logic [N-1:0]      buttons;
  logic [W-1:0]      add_a, add_b;
  logic              add_req;
  logic [W:0]        add_result = '0;
  logic [N*W-1:0]    values_flat;
  logic              sel_valid;
  logic [IW-1:0]     sel_index;
  logic              busy, done;

  pair_add_sequencer #(.N(N), .W(W), .ADD_LAT(ADD_LAT), .INIT(INIT)) dut (
    .clk(clk), .rst(rst), .enable(enable), .buttons(buttons),
    .add_a(add_a), .add_b(add_b), .add_req(add_req), .add_result(add_result),
    .values_flat(values_flat), .sel_valid(sel_valid), .sel_index(sel_index),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Single-stage external adder.
  always @(posedge clk) add_result <= {1'b0, add_a} + {1'b0, add_b};

  typedef struct {
    int         a;
    int         b;
    logic [3:0] ea;
    logic [3:0] eb;
    logic [3:0] er;
  } vec_t;

  vec_t                vecs[7];
  logic [N-1:0][W-1:0] exp_slots;
  logic [N-1:0][W-1:0] all_init;
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_all();
    rst = 1'b1; buttons = '0; enable = 1'b1;
    tick(); tick();
    rst = 1'b0;
    exp_slots = all_init;
    tick();
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    for (int k = 1; k <= 10 && lat == 0; k++) begin
      tick();
      if (done) lat = k;
    end
  endtask

  task automatic do_pair(input logic [N-1:0] a_mask, input int a, input int b,
                         input logic [3:0] ea, input logic [3:0] eb, input logic [3:0] er,
                         input string tag);
    int lat;
    buttons = a_mask; tick(); buttons = '0;
    check({tag, " sel_valid"}, 64'(sel_valid), 64'd1);
    check({tag, " sel_index"}, 64'(sel_index), 64'(a));
    tick();
    buttons[b] = 1'b1; tick(); buttons = '0;
    check({tag, " add_req"}, 64'(add_req), 64'd1);
    check({tag, " add_a"}, 64'(add_a), 64'(ea));
    check({tag, " add_b"}, 64'(add_b), 64'(eb));
    check({tag, " busy"}, 64'(busy), 64'd1);
    wait_done(lat);
    check({tag, " latency"}, 64'(lat), 64'(ADD_LAT + 2));
    exp_slots[a] = er;
    check({tag, " values"}, 64'(values_flat), 64'(exp_slots));
    check({tag, " add_a held"}, 64'(add_a), 64'(ea));
    check({tag, " sel_valid clr"}, 64'(sel_valid), 64'd0);
    tick();
    check({tag, " done pulse"}, 64'(done), 64'd0);
    check({tag, " busy clr"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int lat;
    int dseen;
    logic [3:0] sat_res;
`ifdef PAIR_ADD_SAT_EN
    sat_res = 4'd15;
`else
    sat_res = 4'd2;
`endif
    all_init = {N{4'd3}};
    vecs[0] = '{2, 5, 4'd3, 4'd3, 4'd6};
    vecs[1] = '{1, 1, 4'd3, 4'd3, 4'd6};
    vecs[2] = '{1, 0, 4'd6, 4'd3, 4'd9};
    vecs[3] = '{0, 0, 4'd3, 4'd3, 4'd6};
    vecs[4] = '{0, 4, 4'd6, 4'd3, 4'd9};
    vecs[5] = '{0, 1, 4'd9, 4'd9, sat_res};
    vecs[6] = '{9, 8, 4'd3, 4'd3, 4'd6};

    // Reset state, with button 3 held through the reset release.
    rst = 1'b1; enable = 1'b1; buttons = '0; buttons[3] = 1'b1;
    tick(); tick();
    check("rst add_a", 64'(add_a), 64'd0);
    check("rst add_b", 64'(add_b), 64'd0);
    check("rst add_req", 64'(add_req), 64'd0);
    check("rst sel_valid", 64'(sel_valid), 64'd0);
    check("rst sel_index", 64'(sel_index), 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst values", 64'(values_flat), 64'(all_init));
    rst = 1'b0;
    tick(); tick(); tick();
    check("held through rst", 64'(sel_valid), 64'd0);
    buttons = '0;
    tick();
    exp_slots = all_init;

    for (int i = 0; i < 7; i++) begin
      do_pair(N'(1) << vecs[i].a, vecs[i].a, vecs[i].b, vecs[i].ea, vecs[i].eb, vecs[i].er,
              $sformatf("vec%0d", i));
    end

    // Simultaneous edges resolve to the lowest index.
    buttons[4] = 1'b1;
    do_pair(N'(10'b0010010000), 4, 7, 4'd3, 4'd3, 4'd6, "simul");

    // Abort from PICK_B; a button held across the abort is not a new press.
    buttons[3] = 1'b1; tick(); buttons = '0; tick();
    check("abort sel_valid pre", 64'(sel_valid), 64'd1);
    enable = 1'b0; buttons[6] = 1'b1; tick();
    check("abort sel_valid", 64'(sel_valid), 64'd0);
    check("abort add_req", 64'(add_req), 64'd0);
    enable = 1'b1; tick();
    check("abort held add_req", 64'(add_req), 64'd0);
    check("abort held sel_valid", 64'(sel_valid), 64'd0);
    buttons = '0; tick();
    check("abort values", 64'(values_flat), 64'(exp_slots));

    // Doubling, with a press and enable drop while busy.
    reset_all();
    buttons[1] = 1'b1; tick(); buttons = '0; tick();
    buttons[1] = 1'b1; tick(); buttons = '0;
    check("dbl add_req", 64'(add_req), 64'd1);
    buttons[8] = 1'b1; enable = 1'b0; tick(); buttons = '0;
    wait_done(lat);
    check("dbl latency", 64'(lat + 1), 64'(ADD_LAT + 2));
    exp_slots[1] = 4'd6;
    check("dbl values", 64'(values_flat), 64'(exp_slots));
    enable = 1'b1; tick(); tick();
    check("busy press sel_valid", 64'(sel_valid), 64'd0);
    check("busy press busy", 64'(busy), 64'd0);
    check("busy press add_req", 64'(add_req), 64'd0);

    // Asynchronous reset during ADD_WAIT discards the add.
    buttons[0] = 1'b1; tick(); buttons = '0; tick();
    buttons[1] = 1'b1; tick(); buttons = '0;
    check("midrst busy pre", 64'(busy), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("midrst add_a", 64'(add_a), 64'd0);
    check("midrst add_b", 64'(add_b), 64'd0);
    check("midrst add_req", 64'(add_req), 64'd0);
    check("midrst sel_valid", 64'(sel_valid), 64'd0);
    check("midrst busy", 64'(busy), 64'd0);
    check("midrst values", 64'(values_flat), 64'(all_init));
    tick();
    rst = 1'b0;
    dseen = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (done) dseen++;
    end
    check("midrst no done", 64'(dseen), 64'd0);
    check("midrst values after", 64'(values_flat), 64'(all_init));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
